// File: rtl/frame_buffer_arbiter.sv
// ---------------------------------------------------------------------------
// frame_buffer_arbiter
//
// Shares one single-port synchronous frame-buffer RAM between a camera pixel
// writer and a VGA display reader. Display reads always win the RAM slot.
// Camera pixels wait in a small tagged FIFO and drain into cycles where no
// read is requested. Both sides walk linear frame addresses that restart at
// 0 on a start-of-frame marker and wrap after the last pixel of a frame.
//
// Ports:
//   clk_50      system clock
//   reset       synchronous, active-high reset
//   wr_req      camera pixel strobe
//   wr_sof      marks the strobed pixel as first of a frame
//   wr_data     camera pixel
//   wr_full     write FIFO holds WFIFO_DEPTH entries
//   overflow    sticky flag, a camera pixel was dropped
//   frame_done  one-cycle pulse when the last pixel of a frame is written
//   rd_req      display pixel request
//   rd_sof      marks the request as address 0
//   rd_data     returned display pixel
//   rd_valid    rd_data valid, three cycles after rd_req
//   mem_addr    RAM address (registered)
//   mem_we      RAM write enable (registered)
//   mem_wdata   RAM write data (registered)
//   mem_rdata   RAM read data, valid one cycle after the address edge
// ---------------------------------------------------------------------------
module frame_buffer_arbiter #(
   parameter int ADDR_W       = 17,
   parameter int DATA_W       = 3,
   parameter int FRAME_PIXELS = 76800,
   parameter int WFIFO_DEPTH  = 4
) (
   input  logic              clk_50,
   input  logic              reset,
   input  logic              wr_req,
   input  logic              wr_sof,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_full,
   output logic              overflow,
   output logic              frame_done,
   input  logic              rd_req,
   input  logic              rd_sof,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int PTR_W = $clog2(WFIFO_DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(FRAME_PIXELS - 1);
   localparam logic [PTR_W:0]    FULL_COUNT = (PTR_W + 1)'(WFIFO_DEPTH);

   typedef enum logic {
      WAIT_SOF,
      RUN
   } wr_state_t;

   wr_state_t wr_state;
   wr_state_t wr_state_next;

   logic              push;
   logic              accept;
   logic              pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W:0]    count;
   logic [PTR_W:0]    count_next;
   logic [DATA_W:0]   fifo_mem [WFIFO_DEPTH];
   logic [DATA_W:0]   head;
   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W-1:0] rd_addr;
   logic [ADDR_W-1:0] wr_slot_addr;
   logic [ADDR_W-1:0] rd_slot_addr;
   logic              addr_valid;
   logic              data_pending;

   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
      return (a == LAST_ADDR) ? '0 : a + 1'b1;
   endfunction

   // Until the camera delivers a start-of-frame pixel we have no idea where
   // in the frame its stream is, so stray pixels are thrown away quietly.
   // Once synchronised, every strobe is pushed; only reset resynchronises.
   always_comb begin
      wr_state_next = wr_state;
      push          = 1'b0;
      case (wr_state)
         WAIT_SOF: begin
            if (wr_req && wr_sof) begin
               push          = 1'b1;
               wr_state_next = RUN;
            end
         end
         RUN: begin
            push = wr_req;
         end
         default: begin
            wr_state_next = WAIT_SOF;
         end
      endcase
   end

   // Write FSM state register.
   always_ff @(posedge clk_50) begin
      if (reset) begin
         wr_state <= WAIT_SOF;
      end else begin
         wr_state <= wr_state_next;
      end
   end

   // A full FIFO refuses the push even when the head leaves in the same
   // cycle, so fullness is judged on the count before any pop. The FIFO
   // drains only in cycles the display does not claim.
   always_comb begin
      fifo_full    = (count == FULL_COUNT);
      fifo_empty   = (count == '0);
      accept       = push && !fifo_full;
      pop          = !rd_req && !fifo_empty;
      head         = fifo_mem[rd_ptr];
      wr_slot_addr = head[DATA_W] ? '0 : wr_addr;
      rd_slot_addr = rd_sof ? '0 : rd_addr;
      count_next   = count;
      if (accept && !pop) begin
         count_next = count + 1'b1;
      end else if (!accept && pop) begin
         count_next = count - 1'b1;
      end
   end

   // FIFO storage holds the sof tag above the pixel bits. It needs no reset
   // because the pointers and count decide which entries are meaningful.
   always_ff @(posedge clk_50) begin
      if (accept) begin
         fifo_mem[wr_ptr] <= {wr_sof, wr_data};
      end
   end

   // FIFO bookkeeping plus the full and sticky overflow flags. Pointers wrap
   // on their own because the depth is a power of two.
   always_ff @(posedge clk_50) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         wr_full  <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (accept) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count   <= count_next;
         wr_full <= (count_next == FULL_COUNT);
         if (push && fifo_full) begin
            overflow <= 1'b1;
         end
      end
   end

   // Slot arbiter driving the RAM port. A read request always takes the
   // slot; otherwise the FIFO head is written. A sof-tagged entry or request
   // restarts its side at address 0, and each side steps its own address
   // past whatever it just used. In idle cycles the address is left alone.
   always_ff @(posedge clk_50) begin
      if (reset) begin
         mem_addr   <= '0;
         mem_we     <= 1'b0;
         mem_wdata  <= '0;
         frame_done <= 1'b0;
         wr_addr    <= '0;
         rd_addr    <= '0;
      end else begin
         mem_we     <= 1'b0;
         frame_done <= 1'b0;
         if (rd_req) begin
            mem_addr <= rd_slot_addr;
            rd_addr  <= next_addr(rd_slot_addr);
         end else if (pop) begin
            mem_addr   <= wr_slot_addr;
            mem_we     <= 1'b1;
            mem_wdata  <= head[DATA_W-1:0];
            wr_addr    <= next_addr(wr_slot_addr);
            frame_done <= (wr_slot_addr == LAST_ADDR);
         end
      end
   end

   // Read return path: one stage tracks the address on the RAM port, the
   // next tracks the RAM data cycle, then the pixel is captured. Writes never
   // touch this path, so the latency stays fixed at three cycles, and reset
   // cancels anything in flight.
   always_ff @(posedge clk_50) begin
      if (reset) begin
         addr_valid   <= 1'b0;
         data_pending <= 1'b0;
         rd_valid     <= 1'b0;
         rd_data      <= '0;
      end else begin
         addr_valid   <= rd_req;
         data_pending <= addr_valid;
         rd_valid     <= data_pending;
         if (data_pending) begin
            rd_data <= mem_rdata;
         end
      end
   end

endmodule
